// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: issues rd nicks to dispatch, collects CDB results,
// retires in program order and flushes everything on a mispredicted branch at commit.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int NICK_W    = 5,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int NAME_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              oROB_nick_en,
    output logic [NICK_W-1:0] oROB_nick,
    input  logic              iDP_en,
    input  logic [ADDR_W-1:0] iDP_pc,
    input  logic [NAME_W-1:0] iDP_rd_regnm,
    input  logic              iDP_wr,
    input  logic              iDP_br,
    input  logic              iDP_st,
    input  logic              iDP_pd,
    input  logic              iCDB_en,
    input  logic [NICK_W-1:0] iCDB_nick,
    input  logic [DATA_W-1:0] iCDB_dt,
    input  logic              iCDB_jump,
    input  logic [ADDR_W-1:0] iCDB_tgt,
    input  logic [NICK_W-1:0] iQ_rs1_nick,
    input  logic [NICK_W-1:0] iQ_rs2_nick,
    output logic              oQ_rs1_rdy,
    output logic [DATA_W-1:0] oQ_rs1_dt,
    output logic              oQ_rs2_rdy,
    output logic [DATA_W-1:0] oQ_rs2_dt,
    output logic              oCM_en,
    output logic [NAME_W-1:0] oCM_rd_regnm,
    output logic [NICK_W-1:0] oCM_nick,
    output logic [DATA_W-1:0] oCM_dt,
    output logic              oCM_st_en,
    output logic [NICK_W-1:0] oCM_st_nick,
    output logic              oFL_en,
    output logic [ADDR_W-1:0] oFL_pc
);

    localparam int                PTR_W    = $clog2(ROB_DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(ROB_DEPTH);
    localparam logic [NICK_W-1:0] MAX_NICK = NICK_W'(ROB_DEPTH);

    logic [PTR_W-1:0]     r_head, r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [ROB_DEPTH-1:0] r_valid, r_ready;

    logic [ADDR_W-1:0]    r_pc  [ROB_DEPTH];
    logic [NAME_W-1:0]    r_rd  [ROB_DEPTH];
    logic [DATA_W-1:0]    r_dt  [ROB_DEPTH];
    logic [ADDR_W-1:0]    r_tgt [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] r_wr, r_br, r_st, r_pd, r_jump;

    logic                 w_full, w_alloc, w_commit, w_mispredict, w_cdb_hit;
    logic [PTR_W-1:0]     w_cdb_slot;

    function automatic logic [NICK_W-1:0] nick_of(input logic [PTR_W-1:0] ptr);
        return NICK_W'(ptr) + NICK_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] slot_of(input logic [NICK_W-1:0] nick);
        return PTR_W'(nick - NICK_W'(1));
    endfunction

    // Returns {ready, data}; a same-cycle CDB broadcast wins over the stored slot.
    function automatic logic [DATA_W:0] lookup(input logic [NICK_W-1:0] nick);
        logic [PTR_W-1:0] slot;
        slot = slot_of(nick);
        if (nick == '0)                              return '0;
        if (iCDB_en && (iCDB_nick == nick))          return {1'b1, iCDB_dt};
        if ((nick > MAX_NICK) || !r_valid[slot])     return '0;
        return {r_ready[slot], r_dt[slot]};
    endfunction

    assign w_full       = (r_count == FULL_CNT);
    assign w_alloc      = iDP_en & ~w_full;
    assign w_commit     = (r_count != '0) & r_ready[r_head];
    assign w_mispredict = w_commit & r_br[r_head] & (r_jump[r_head] != r_pd[r_head]);
    assign w_cdb_slot   = slot_of(iCDB_nick);
    assign w_cdb_hit    = iCDB_en & (iCDB_nick != '0) & (iCDB_nick <= MAX_NICK) & r_valid[w_cdb_slot];

    assign oROB_nick_en = ~w_full;
    assign oROB_nick    = nick_of(r_tail);

    always_comb begin
        {oQ_rs1_rdy, oQ_rs1_dt} = lookup(iQ_rs1_nick);
        {oQ_rs2_rdy, oQ_rs2_dt} = lookup(iQ_rs2_nick);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_valid      <= '0;
            r_ready      <= '0;
            oCM_en       <= 1'b0;
            oCM_rd_regnm <= '0;
            oCM_nick     <= '0;
            oCM_dt       <= '0;
            oCM_st_en    <= 1'b0;
            oCM_st_nick  <= '0;
            oFL_en       <= 1'b0;
            oFL_pc       <= '0;
        end else if (rdy) begin
            oCM_en    <= w_commit & r_wr[r_head] & (r_rd[r_head] != '0);
            oCM_st_en <= w_commit & r_st[r_head];
            oFL_en    <= w_mispredict;
            if (w_commit) begin
                oCM_rd_regnm <= r_rd[r_head];
                oCM_nick     <= nick_of(r_head);
                oCM_dt       <= r_dt[r_head];
                oCM_st_nick  <= nick_of(r_head);
            end
            if (w_mispredict) begin
                oFL_pc  <= r_jump[r_head] ? r_tgt[r_head] : r_pc[r_head] + ADDR_W'(4);
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_valid <= '0;
                r_ready <= '0;
            end else begin
                // NOTE: non-blocking writes to the same slot resolve last-wins, so the
                // order CDB -> commit -> allocate keeps a full-buffer reuse of head clean.
                if (w_cdb_hit) r_ready[w_cdb_slot] <= 1'b1;
                if (w_commit) begin
                    r_valid[r_head] <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + PTR_W'(1);
                end
                if (w_alloc) begin
                    r_valid[r_tail] <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_commit);
            end
        end else begin
            oCM_en    <= 1'b0;
            oCM_st_en <= 1'b0;
            oFL_en    <= 1'b0;
        end
    end

    // NOTE: payload storage has no reset; it is only ever read through a set valid/ready bit.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (w_alloc) begin
                r_pc[r_tail] <= iDP_pc;
                r_rd[r_tail] <= iDP_rd_regnm;
                r_wr[r_tail] <= iDP_wr;
                r_br[r_tail] <= iDP_br;
                r_st[r_tail] <= iDP_st;
                r_pd[r_tail] <= iDP_pd;
            end
            if (w_cdb_hit) begin
                r_dt[w_cdb_slot]   <= iCDB_dt;
                r_jump[w_cdb_slot] <= iCDB_jump;
                r_tgt[w_cdb_slot]  <= iCDB_tgt;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based program-order model checked every
// cycle, plus hand-computed literal expectations at the interesting points.
module tb_reorder_buffer;

    localparam int DEPTH = 16;

    logic        clk, rst, rdy;
    logic        oROB_nick_en;
    logic [4:0]  oROB_nick;
    logic        iDP_en, iDP_wr, iDP_br, iDP_st, iDP_pd;
    logic [31:0] iDP_pc;
    logic [4:0]  iDP_rd_regnm;
    logic        iCDB_en, iCDB_jump;
    logic [4:0]  iCDB_nick;
    logic [31:0] iCDB_dt, iCDB_tgt;
    logic [4:0]  iQ_rs1_nick, iQ_rs2_nick;
    logic        oQ_rs1_rdy, oQ_rs2_rdy;
    logic [31:0] oQ_rs1_dt, oQ_rs2_dt;
    logic        oCM_en, oCM_st_en, oFL_en;
    logic [4:0]  oCM_rd_regnm, oCM_nick, oCM_st_nick;
    logic [31:0] oCM_dt, oFL_pc;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .oROB_nick_en(oROB_nick_en), .oROB_nick(oROB_nick),
        .iDP_en(iDP_en), .iDP_pc(iDP_pc), .iDP_rd_regnm(iDP_rd_regnm), .iDP_wr(iDP_wr),
        .iDP_br(iDP_br), .iDP_st(iDP_st), .iDP_pd(iDP_pd),
        .iCDB_en(iCDB_en), .iCDB_nick(iCDB_nick), .iCDB_dt(iCDB_dt),
        .iCDB_jump(iCDB_jump), .iCDB_tgt(iCDB_tgt),
        .iQ_rs1_nick(iQ_rs1_nick), .iQ_rs2_nick(iQ_rs2_nick),
        .oQ_rs1_rdy(oQ_rs1_rdy), .oQ_rs1_dt(oQ_rs1_dt),
        .oQ_rs2_rdy(oQ_rs2_rdy), .oQ_rs2_dt(oQ_rs2_dt),
        .oCM_en(oCM_en), .oCM_rd_regnm(oCM_rd_regnm), .oCM_nick(oCM_nick), .oCM_dt(oCM_dt),
        .oCM_st_en(oCM_st_en), .oCM_st_nick(oCM_st_nick),
        .oFL_en(oFL_en), .oFL_pc(oFL_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  nick;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wr, br, st, pd, ready, jump;
        logic [31:0] dt, tgt;
    } ent_t;

    ent_t        q[$];
    int          head_nick;
    logic        e_cm_en, e_st_en, e_fl_en;
    logic [4:0]  e_cm_rd, e_cm_nick, e_st_nick;
    logic [31:0] e_cm_dt, e_fl_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head_nick = 1;
        e_cm_en = 1'b0; e_st_en = 1'b0; e_fl_en = 1'b0;
        e_cm_rd = '0; e_cm_nick = '0; e_st_nick = '0;
        e_cm_dt = '0; e_fl_pc = '0;
    endtask

    // Program-order model: the queue front is the oldest instruction.
    task automatic model_step();
        int   sz, tnick;
        bit   commit, flush;
        ent_t e;
        if (!rst) begin model_reset(); return; end
        if (!rdy) begin e_cm_en = 1'b0; e_st_en = 1'b0; e_fl_en = 1'b0; return; end
        sz     = q.size();
        tnick  = ((head_nick - 1 + sz) % DEPTH) + 1;
        commit = (sz > 0) && q[0].ready;
        flush  = 1'b0;
        e_cm_en = 1'b0; e_st_en = 1'b0; e_fl_en = 1'b0;
        if (commit) begin
            e = q[0];
            e_cm_en   = e.wr && (e.rd != 0);
            e_st_en   = e.st;
            e_cm_rd   = e.rd;
            e_cm_nick = e.nick;
            e_st_nick = e.nick;
            e_cm_dt   = e.dt;
            if (e.br && (e.jump != e.pd)) begin
                flush   = 1'b1;
                e_fl_en = 1'b1;
                e_fl_pc = e.jump ? e.tgt : e.pc + 32'd4;
            end
        end
        if (flush) begin q.delete(); head_nick = 1; return; end
        if (iCDB_en) begin
            foreach (q[i]) begin
                if (q[i].nick == iCDB_nick) begin
                    q[i].ready = 1'b1; q[i].dt = iCDB_dt;
                    q[i].jump = iCDB_jump; q[i].tgt = iCDB_tgt;
                end
            end
        end
        if (commit) begin q.delete(0); head_nick = (head_nick % DEPTH) + 1; end
        if (iDP_en && (sz < DEPTH)) begin
            e.nick = 5'(tnick); e.pc = iDP_pc; e.rd = iDP_rd_regnm; e.wr = iDP_wr;
            e.br = iDP_br; e.st = iDP_st; e.pd = iDP_pd; e.ready = 1'b0;
            e.jump = 1'b0; e.dt = '0; e.tgt = '0;
            q.push_back(e);
        end
    endtask

    task automatic model_lookup(input logic [4:0] n, output logic r, output logic [31:0] d);
        r = 1'b0; d = '0;
        if (n == 0) return;
        if (iCDB_en && (iCDB_nick == n)) begin r = 1'b1; d = iCDB_dt; return; end
        foreach (q[i]) if (q[i].nick == n) begin r = q[i].ready; d = q[i].dt; end
    endtask

    task automatic compare();
        int          sz, tn;
        logic        r;
        logic [31:0] d;
        sz = q.size();
        tn = ((head_nick - 1 + sz) % DEPTH) + 1;
        check("nick_en",  64'(oROB_nick_en), 64'(sz < DEPTH));
        check("nick",     64'(oROB_nick),    64'(tn));
        check("cm_en",    64'(oCM_en),       64'(e_cm_en));
        check("cm_rd",    64'(oCM_rd_regnm), 64'(e_cm_rd));
        check("cm_nick",  64'(oCM_nick),     64'(e_cm_nick));
        check("cm_dt",    64'(oCM_dt),       64'(e_cm_dt));
        check("st_en",    64'(oCM_st_en),    64'(e_st_en));
        check("st_nick",  64'(oCM_st_nick),  64'(e_st_nick));
        check("fl_en",    64'(oFL_en),       64'(e_fl_en));
        check("fl_pc",    64'(oFL_pc),       64'(e_fl_pc));
        model_lookup(iQ_rs1_nick, r, d);
        check("rs1_rdy", 64'(oQ_rs1_rdy), 64'(r));
        if (r || (iQ_rs1_nick == 0)) check("rs1_dt", 64'(oQ_rs1_dt), 64'(d));
        model_lookup(iQ_rs2_nick, r, d);
        check("rs2_rdy", 64'(oQ_rs2_rdy), 64'(r));
        if (r || (iQ_rs2_nick == 0)) check("rs2_dt", 64'(oQ_rs2_dt), 64'(d));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare();
        end
    end

    task automatic clear_inputs();
        iDP_en = 1'b0; iDP_pc = '0; iDP_rd_regnm = '0;
        iDP_wr = 1'b0; iDP_br = 1'b0; iDP_st = 1'b0; iDP_pd = 1'b0;
        iCDB_en = 1'b0; iCDB_nick = '0; iCDB_dt = '0; iCDB_jump = 1'b0; iCDB_tgt = '0;
        iQ_rs1_nick = '0; iQ_rs2_nick = '0;
    endtask

    task automatic set_dp(input logic [31:0] pc, input logic [4:0] rd,
                          input logic wr, input logic br, input logic st, input logic pd);
        iDP_en = 1'b1; iDP_pc = pc; iDP_rd_regnm = rd;
        iDP_wr = wr; iDP_br = br; iDP_st = st; iDP_pd = pd;
    endtask

    task automatic set_cdb(input logic [4:0] nick, input logic [31:0] dt,
                           input logic jump, input logic [31:0] tgt);
        iCDB_en = 1'b1; iCDB_nick = nick; iCDB_dt = dt; iCDB_jump = jump; iCDB_tgt = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        clear_inputs();
        model_reset();
        #2;
        check("rst_nick",    64'(oROB_nick),    64'd1);
        check("rst_nick_en", 64'(oROB_nick_en), 64'd1);
        check("rst_cm_en",   64'(oCM_en),       64'd0);
        tick(); tick();
        rst = 1'b1;

        // three dispatches take nicks 1,2,3
        for (int i = 0; i < 3; i++) begin
            set_dp(32'h1000 + 32'(4 * i), 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0);
            #1 check("t1_nick_issued", 64'(oROB_nick), 64'(i + 1));
            tick();
        end
        clear_inputs();
        #1 check("t1_nick_after", 64'(oROB_nick), 64'd4);
        tick(); tick();
        check("t1_no_commit", 64'(oCM_en), 64'd0);

        // out-of-order completion, in-order retirement
        set_cdb(5'd2, 32'h55, 1'b0, '0); tick();
        clear_inputs(); tick();
        check("t2_hold", 64'(oCM_en), 64'd0);
        set_cdb(5'd1, 32'h11, 1'b0, '0); tick();
        clear_inputs(); tick();
        check("t2_c1_en",   64'(oCM_en),   64'd1);
        check("t2_c1_nick", 64'(oCM_nick), 64'd1);
        check("t2_c1_dt",   64'(oCM_dt),   64'h11);
        tick();
        check("t2_c2_nick", 64'(oCM_nick), 64'd2);
        check("t2_c2_dt",   64'(oCM_dt),   64'h55);

        // same-cycle CDB bypass on operand lookup
        iQ_rs1_nick = 5'd3;
        set_cdb(5'd3, 32'hAB, 1'b0, '0);
        #1;
        check("t6_byp_rdy", 64'(oQ_rs1_rdy), 64'd1);
        check("t6_byp_dt",  64'(oQ_rs1_dt),  64'hAB);
        check("t6_nick0",   64'(oQ_rs2_rdy), 64'd0);
        tick();
        clear_inputs(); iQ_rs1_nick = 5'd3;
        tick();

        // store release and rd=0 write
        set_dp(32'h2000, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        set_dp(32'h2004, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); set_cdb(5'd4, 32'h44, 1'b0, '0); tick();
        clear_inputs(); set_cdb(5'd5, 32'h5A, 1'b0, '0); tick();
        check("t5_st_en",   64'(oCM_st_en),   64'd1);
        check("t5_st_cm",   64'(oCM_en),      64'd0);
        check("t5_st_nick", 64'(oCM_st_nick), 64'd4);
        clear_inputs(); tick();
        check("t5_rd0_en",   64'(oCM_en),   64'd0);
        check("t5_rd0_nick", 64'(oCM_nick), 64'd5);
        #1 check("t5_head_adv", 64'(oROB_nick), 64'd6);

        // rdy=0 freezes state and blanks the commit pulse
        set_dp(32'h3000, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        clear_inputs(); set_cdb(5'd6, 32'h66, 1'b0, '0); tick();
        clear_inputs(); rdy = 1'b0;
        set_dp(32'h3004, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        check("frz_cm_en", 64'(oCM_en), 64'd0);
        tick();
        clear_inputs(); rdy = 1'b1; tick();
        check("frz_cm_nick", 64'(oCM_nick), 64'd6);
        check("frz_cm_dt",   64'(oCM_dt),   64'h66);
        #1 check("frz_no_alloc", 64'(oROB_nick), 64'd7);

        // fill to capacity, wrap the tail, ignore dispatch while full
        for (int i = 0; i < DEPTH; i++) begin
            set_dp(32'h4000 + 32'(4 * i), 5'((i % 31) + 1), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        clear_inputs();
        #1;
        check("t3_full_en",   64'(oROB_nick_en), 64'd0);
        check("t3_full_nick", 64'(oROB_nick),    64'd7);
        set_dp(32'hDEAD0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        clear_inputs();
        #1 check("t3_17th_ign", 64'(oROB_nick_en), 64'd0);
        set_cdb(5'd7, 32'h77, 1'b0, '0); tick();
        clear_inputs(); set_cdb(5'd8, 32'h88, 1'b0, '0); tick();
        clear_inputs();
        #1;
        check("t3_c7_nick", 64'(oCM_nick),     64'd7);
        check("t3_c7_free", 64'(oROB_nick_en), 64'd1);
        set_dp(32'h5000, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        clear_inputs();
        #1;
        check("t3_ac_cm_nick", 64'(oCM_nick),     64'd8);
        check("t3_ac_nick",    64'(oROB_nick),    64'd8);
        check("t3_ac_en",      64'(oROB_nick_en), 64'd1);

        // asynchronous reset mid-stream
        check("pre_rst_cm_en", 64'(oCM_en), 64'd1);
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_rst_cm_en",   64'(oCM_en),       64'd0);
        check("mid_rst_cm_dt",   64'(oCM_dt),       64'd0);
        check("mid_rst_nick",    64'(oROB_nick),    64'd1);
        check("mid_rst_nick_en", 64'(oROB_nick_en), 64'd1);
        tick();
        rst = 1'b1;

        // taken mispredict flushes and discards same-cycle dispatch/CDB
        set_dp(32'h100, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        set_dp(32'h104, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        clear_inputs(); set_cdb(5'd1, 32'h104, 1'b1, 32'h200); tick();
        clear_inputs();
        set_dp(32'h108, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); set_cdb(5'd2, 32'h22, 1'b0, '0);
        tick();
        clear_inputs(); iQ_rs1_nick = 5'd2;
        #1;
        check("t4_fl_en",   64'(oFL_en),       64'd1);
        check("t4_fl_pc",   64'(oFL_pc),       64'h200);
        check("t4_cm_nick", 64'(oCM_nick),     64'd1);
        check("t4_empty",   64'(oROB_nick),    64'd1);
        check("t4_young",   64'(oQ_rs1_rdy),   64'd0);
        tick();
        check("t4_fl_pulse", 64'(oFL_en), 64'd0);

        // not-taken mispredict: fall-through wraps past the top of the address space
        set_dp(32'hFFFF_FFFC, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        clear_inputs(); set_cdb(5'd1, 32'h0, 1'b0, 32'h999); tick();
        clear_inputs(); tick();
        check("nt_fl_en", 64'(oFL_en), 64'd1);
        check("nt_fl_pc", 64'(oFL_pc), 64'd0);
        check("nt_cm_en", 64'(oCM_en), 64'd0);

        // correct prediction, with out-of-range and zero CDB nicks ignored
        set_dp(32'h300, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1); tick();
        clear_inputs(); set_cdb(5'd20, 32'h20, 1'b1, 32'h123); iQ_rs2_nick = 5'd20; tick();
        clear_inputs(); set_cdb(5'd0, 32'h1, 1'b1, 32'h1); tick();
        clear_inputs(); tick();
        check("ok_pending", 64'(oCM_en), 64'd0);
        set_cdb(5'd1, 32'h304, 1'b1, 32'h400); tick();
        clear_inputs(); tick();
        check("ok_fl_en", 64'(oFL_en), 64'd0);
        check("ok_cm_en", 64'(oCM_en), 64'd1);
        check("ok_cm_dt", 64'(oCM_dt), 64'h304);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
